// File: rtl/multimode_ff_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | multimode_ff_bank : N-channel bit bank, each channel a D/T/SR/JK flip-flop
// | Rev 1.0
// +----------------------------------------------------------------------------
module multimode_ff_bank #(
  parameter int            N            = 4,
  parameter logic [N-1:0]  RESET_VAL    = {N{1'b0}},
  parameter logic [1:0]    DEFAULT_MODE = 2'b10,
  parameter int            SR11_POLICY  = 0,
  parameter int            SEL_W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             en,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             mode_wr,
  input  logic [SEL_W-1:0] mode_sel,
  input  logic [1:0]       mode_data,
  input  logic             err_clr,
  output logic [N-1:0]     q,
  output logic [N-1:0]     qbar,
  output logic [2*N-1:0]   mode,
  output logic [N-1:0]     err
);

  localparam logic [1:0] c_MODE_D  = 2'b00;
  localparam logic [1:0] c_MODE_T  = 2'b01;
  localparam logic [1:0] c_MODE_SR = 2'b10;
  localparam logic [1:0] c_MODE_JK = 2'b11;

  // Out-of-range selects never match any channel index, so they write nothing.
  logic [31:0] w_sel_ext;
  assign w_sel_ext = 32'(mode_sel);

  generate
    for (genvar i = 0; i < N; i++) begin : g_ch
      logic       r_q;
      logic [1:0] r_mode;
      logic       r_err;
      logic       w_next;
      logic       w_sr11;
      logic       w_wr;
      logic       w_err_set;

      assign w_wr      = mode_wr && (w_sel_ext == i);
      assign w_err_set = en && (r_mode == c_MODE_SR) && a[i] && b[i];

      always_comb begin
        w_sr11 = r_q;
        case (SR11_POLICY)
          1:       w_sr11 = 1'b1;
          2:       w_sr11 = 1'b0;
          3:       w_sr11 = ~r_q;
          default: w_sr11 = r_q;
        endcase
      end

      always_comb begin
        w_next = r_q;
        case (r_mode)
          c_MODE_D:  w_next = a[i];
          c_MODE_T:  w_next = a[i] ? ~r_q : r_q;
          c_MODE_SR: begin
            case ({a[i], b[i]})
              2'b01:   w_next = 1'b0;
              2'b10:   w_next = 1'b1;
              2'b11:   w_next = w_sr11;
              default: w_next = r_q;
            endcase
          end
          c_MODE_JK: begin
            case ({a[i], b[i]})
              2'b01:   w_next = 1'b0;
              2'b10:   w_next = 1'b1;
              2'b11:   w_next = ~r_q;
              default: w_next = r_q;
            endcase
          end
          default:   w_next = r_q;
        endcase
      end

      // The data update above reads r_mode before a same-edge write lands.
      always_ff @(posedge clk) begin
        if (!RST) begin
          r_q    <= RESET_VAL[i];
          r_mode <= DEFAULT_MODE;
          r_err  <= 1'b0;
        end else begin
          if (en) begin
            r_q <= w_next;
          end
          if (w_wr) begin
            r_mode <= mode_data;
          end
          if (w_err_set) begin
            r_err <= 1'b1;
          end else if (err_clr) begin
            r_err <= 1'b0;
          end
        end
      end

      assign q[i]           = r_q;
      assign qbar[i]        = ~r_q;
      assign mode[2*i +: 2] = r_mode;
      assign err[i]         = r_err;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multimode_ff_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_multimode_ff_bank : scoreboard bench for multimode_ff_bank (N=4)
// | Rev 1.0
// +----------------------------------------------------------------------------
module tb_multimode_ff_bank;

  typedef struct {
    string      name;
    int         dut;
    logic [3:0] q;
    logic [7:0] mode;
    logic [3:0] err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, en_p;
  logic [3:0] a, b, a_p, b_p;
  logic       mode_wr;
  logic [2:0] mode_sel;
  logic [1:0] mode_data;
  logic       err_clr;

  logic [3:0] q0, qb0, e0, q1, qb1, e1, q2, qb2, e2, q3, qb3, e3;
  logic [7:0] m0, m1, m2, m3;

  logic       zero_wr = 1'b0;
  logic [1:0] zero_sel = 2'b00;
  logic [1:0] zero_data = 2'b00;
  logic       zero_clr = 1'b0;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  multimode_ff_bank #(.N(4), .SR11_POLICY(0), .SEL_W(3)) dut (
    .clk(clk), .RST(rst), .en(en), .a(a), .b(b), .mode_wr(mode_wr),
    .mode_sel(mode_sel), .mode_data(mode_data), .err_clr(err_clr),
    .q(q0), .qbar(qb0), .mode(m0), .err(e0));

  multimode_ff_bank #(.N(4), .SR11_POLICY(1)) dut_p1 (
    .clk(clk), .RST(rst), .en(en_p), .a(a_p), .b(b_p), .mode_wr(zero_wr),
    .mode_sel(zero_sel), .mode_data(zero_data), .err_clr(zero_clr),
    .q(q1), .qbar(qb1), .mode(m1), .err(e1));

  multimode_ff_bank #(.N(4), .SR11_POLICY(2)) dut_p2 (
    .clk(clk), .RST(rst), .en(en_p), .a(a_p), .b(b_p), .mode_wr(zero_wr),
    .mode_sel(zero_sel), .mode_data(zero_data), .err_clr(zero_clr),
    .q(q2), .qbar(qb2), .mode(m2), .err(e2));

  multimode_ff_bank #(.N(4), .SR11_POLICY(3)) dut_p3 (
    .clk(clk), .RST(rst), .en(en_p), .a(a_p), .b(b_p), .mode_wr(zero_wr),
    .mode_sel(zero_sel), .mode_data(zero_data), .err_clr(zero_clr),
    .q(q3), .qbar(qb3), .mode(m3), .err(e3));

  // Monitor: every expectation queued before an edge is checked just after it.
  initial begin
    exp_t       it;
    logic [3:0] aq, aqb, ae;
    logic [7:0] am;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.dut)
          1:       begin aq = q1; aqb = qb1; am = m1; ae = e1; end
          2:       begin aq = q2; aqb = qb2; am = m2; ae = e2; end
          3:       begin aq = q3; aqb = qb3; am = m3; ae = e3; end
          default: begin aq = q0; aqb = qb0; am = m0; ae = e0; end
        endcase
        tests++;
        if (aq !== it.q || aqb !== ~it.q || am !== it.mode || ae !== it.err) begin
          fails++;
          $display("FAIL %s (dut%0d): got q=%b qbar=%b mode=%h err=%b, expected q=%b qbar=%b mode=%h err=%b",
                   it.name, it.dut, aq, aqb, am, ae, it.q, ~it.q, it.mode, it.err);
        end
      end
    end
  end

  task automatic expect_out(input string name, input int d, input logic [3:0] eq,
                            input logic [7:0] em, input logic [3:0] ee);
    exp_t it;
    it.name = name; it.dut = d; it.q = eq; it.mode = em; it.err = ee;
    sb.push_back(it);
  endtask

  task automatic drive(input logic r, input logic e, input logic [3:0] av,
                       input logic [3:0] bv, input logic wr, input logic [2:0] sel,
                       input logic [1:0] data, input logic clr);
    rst = r; en = e; a = av; b = bv;
    mode_wr = wr; mode_sel = sel; mode_data = data; err_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    en_p = 1'b0; a_p = 4'h0; b_p = 4'h0;

    // Reset with junk on the inputs
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 4'($urandom), 4'($urandom), 1'b1, 3'($urandom), 2'($urandom), 1'b0);
      expect_out("reset", 0, 4'b0000, 8'hAA, 4'b0000);
      for (int d = 1; d < 4; d++) expect_out("reset_p", d, 4'b0000, 8'hAA, 4'b0000);
      tick();
    end

    // SR11 policy sweep on the auxiliary instances
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 2'b00, 1'b0);
    en_p = 1'b1; a_p = 4'b0001; b_p = 4'b0001;
    expect_out("pol1_e1", 1, 4'b0001, 8'hAA, 4'b0001);
    expect_out("pol2_e1", 2, 4'b0000, 8'hAA, 4'b0001);
    expect_out("pol3_e1", 3, 4'b0001, 8'hAA, 4'b0001);
    expect_out("idle_en0", 0, 4'b0000, 8'hAA, 4'b0000);
    tick();
    expect_out("pol1_e2", 1, 4'b0001, 8'hAA, 4'b0001);
    expect_out("pol2_e2", 2, 4'b0000, 8'hAA, 4'b0001);
    expect_out("pol3_e2", 3, 4'b0000, 8'hAA, 4'b0001);
    tick();
    en_p = 1'b0; a_p = 4'h0; b_p = 4'h0;

    // SR truth table, policy 0, channel 0
    drive(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 3'd0, 2'b00, 1'b0);
    expect_out("sr_set", 0, 4'b0001, 8'hAA, 4'b0000); tick();
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0, 2'b00, 1'b0);
    expect_out("sr_hold", 0, 4'b0001, 8'hAA, 4'b0000); tick();
    drive(1'b1, 1'b1, 4'b0000, 4'b0001, 1'b0, 3'd0, 2'b00, 1'b0);
    expect_out("sr_reset", 0, 4'b0000, 8'hAA, 4'b0000); tick();
    drive(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0, 3'd0, 2'b00, 1'b0);
    expect_out("sr_11", 0, 4'b0000, 8'hAA, 4'b0001); tick();
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0, 2'b00, 1'b0);
    expect_out("err_sticky", 0, 4'b0000, 8'hAA, 4'b0001); tick();
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0, 2'b00, 1'b1);
    expect_out("err_clr", 0, 4'b0000, 8'hAA, 4'b0000); tick();

    // Mode switch timing on channel 2
    drive(1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 3'd0, 2'b00, 1'b0);
    expect_out("ch2_set", 0, 4'b0100, 8'hAA, 4'b0000); tick();
    drive(1'b1, 1'b1, 4'b0100, 4'b0000, 1'b1, 3'd2, 2'b01, 1'b0);
    expect_out("wr_old_mode", 0, 4'b0100, 8'h9A, 4'b0000); tick();
    drive(1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 3'd0, 2'b00, 1'b0);
    expect_out("new_mode_t", 0, 4'b0000, 8'h9A, 4'b0000); tick();
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 3'd5, 2'b00, 1'b0);
    expect_out("sel5_ignored", 0, 4'b0000, 8'h9A, 4'b0000); tick();
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 3'd4, 2'b00, 1'b0);
    expect_out("sel4_ignored", 0, 4'b0000, 8'h9A, 4'b0000); tick();

    // Channel 1 to JK; enable gating, including an SR 11 on channel 3
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 3'd1, 2'b11, 1'b0);
    expect_out("ch1_jk", 0, 4'b0000, 8'h9E, 4'b0000); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 4'b1010, 4'b1010, 1'b0, 3'd0, 2'b00, 1'b0);
      expect_out("en0_hold", 0, 4'b0000, 8'h9E, 4'b0000); tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0, 3'd0, 2'b00, 1'b0);
      expect_out("jk_toggle", 0, (k == 1) ? 4'b0000 : 4'b0010, 8'h9E, 4'b0000); tick();
    end

    // Set beats clear; then reset discards a same-edge mode write
    drive(1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0, 3'd0, 2'b00, 1'b1);
    expect_out("set_beats_clr", 0, 4'b0010, 8'h9E, 4'b1000); tick();
    drive(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b1, 3'd3, 2'b00, 1'b0);
    expect_out("midop_reset", 0, 4'b0000, 8'hAA, 4'b0000); tick();

    // D mode on channel 0: b ignored, no error
    drive(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1, 3'd0, 2'b00, 1'b0);
    expect_out("d_wr_old_sr", 0, 4'b0001, 8'hA8, 4'b0000); tick();
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0, 2'b00, 1'b0);
    expect_out("d_zero", 0, 4'b0000, 8'hA8, 4'b0000); tick();
    drive(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0, 3'd0, 2'b00, 1'b0);
    expect_out("d_one_b1", 0, 4'b0001, 8'hA8, 4'b0000); tick();

    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0, 2'b00, 1'b0);
    tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
